// File: rtl/i_fetch_queue_pkg.sv
// Shared fetch-queue definitions: instruction/line geometry and line word slicing.
// Word 0 (lowest address) sits in the most significant 32 bits of a line.
package i_fetch_queue_pkg;

   localparam int INST_W         = 32;
   localparam int LINE_W         = 128;
   localparam int WORDS_PER_LINE = 4;
   localparam int LPC_W          = 28;

   function automatic logic [INST_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                   input logic [1:0]        idx);
      logic [INST_W-1:0] w;
      case (idx)
         2'd0:    w = line[127:96];
         2'd1:    w = line[95:64];
         2'd2:    w = line[63:32];
         default: w = line[31:0];
      endcase
      return w;
   endfunction

endpackage

// File: rtl/ifq_line_buf.sv
// Line storage for the fetch queue: DEPTH entries of {128-bit line, line PC[31:4]}.
// Synchronous write, asynchronous read; holds data only, so it has no reset.
module ifq_line_buf
   import i_fetch_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [LINE_W-1:0] wr_line,
   input  logic [LPC_W-1:0]  wr_lpc,
   input  logic [AW-1:0]     rd_addr,
   output logic [LINE_W-1:0] rd_line,
   output logic [LPC_W-1:0]  rd_lpc
);

   logic [LINE_W-1:0] line_mem [DEPTH];
   logic [LPC_W-1:0]  lpc_mem  [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         line_mem[wr_addr] <= wr_line;
         lpc_mem[wr_addr]  <= wr_lpc;
      end
   end

   assign rd_line = line_mem[rd_addr];
   assign rd_lpc  = lpc_mem[rd_addr];

endmodule

// File: rtl/i_fetch_queue.sv
// Instruction fetch queue: issues line-aligned fetches to the i_cache, buffers returned
// lines and hands instructions one at a time to dispatch; flushes on redirect.
module i_fetch_queue
   import i_fetch_queue_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic         clk,
   input  logic         reset,
   output logic [31:0]  Cache_pc,
   output logic         Cache_rd_en,
   input  logic [127:0] Cache_dout,
   input  logic         Cache_dout_valid,
   output logic [31:0]  Inst,
   output logic [31:0]  Pc_out,
   output logic         Empty,
   input  logic         Dispatch_rd,
   input  logic [31:0]  Jmp_branch_address,
   input  logic         Jmp_branch_valid
);

   localparam int             AW        = $clog2(DEPTH);
   localparam logic [AW:0]    DEPTH_C   = (AW+1)'(DEPTH);
   localparam logic [AW:0]    CNT_ONE   = {{AW{1'b0}}, 1'b1};
   localparam logic [AW-1:0]  PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [1:0]     LAST_WORD = 2'(WORDS_PER_LINE - 1);

   logic [31:0]       fetch_pc;
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [AW:0]       count;
   logic [1:0]        word_off;
   logic [1:0]        start_off;
   logic              skip_pend;
   logic              outstanding;
   logic              discard;
   logic              rd_en_q;

   logic [LINE_W-1:0] head_line_p0;
   logic [LPC_W-1:0]  head_lpc_p0;

   logic              empty;
   logic              issue;
   logic              do_fill;
   logic              do_drain;
   logic              pop_line;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^Jmp_branch_address[1:0];

   assign empty    = (count == '0);
   assign issue    = !outstanding && (count < DEPTH_C);
   assign do_fill  = Cache_dout_valid && outstanding && !discard;
   assign do_drain = Dispatch_rd && !empty;
   assign pop_line = do_drain && (word_off == LAST_WORD);

   ifq_line_buf #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_line_buf (
      .clk     (clk),
      .wr_en   (do_fill && !Jmp_branch_valid),
      .wr_addr (wr_ptr),
      .wr_line (Cache_dout),
      .wr_lpc  (fetch_pc[31:4]),
      .rd_addr (rd_ptr),
      .rd_line (head_line_p0),
      .rd_lpc  (head_lpc_p0)
   );

   // Control state; redirect outranks fill, drain and fetch in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc    <= RESET_PC;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         word_off    <= 2'd0;
         start_off   <= 2'd0;
         skip_pend   <= 1'b0;
         outstanding <= 1'b0;
         discard     <= 1'b0;
         rd_en_q     <= 1'b0;
      end else if (Jmp_branch_valid) begin
         fetch_pc    <= {Jmp_branch_address[31:4], 4'b0000};
         start_off   <= Jmp_branch_address[3:2];
         skip_pend   <= 1'b1;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         word_off    <= 2'd0;
         // A response arriving this very cycle is already being dropped here.
         discard     <= outstanding && !Cache_dout_valid;
         outstanding <= 1'b0;
         rd_en_q     <= 1'b0;
      end else begin
         rd_en_q <= issue;
         discard <= 1'b0;
         if (issue)
            outstanding <= 1'b1;
         else if (Cache_dout_valid)
            outstanding <= 1'b0;

         if (do_fill) begin
            wr_ptr   <= wr_ptr + PTR_ONE;
            fetch_pc <= fetch_pc + 32'd16;
            if (skip_pend) begin
               word_off  <= start_off;
               skip_pend <= 1'b0;
            end
         end

         if (do_drain) begin
            if (pop_line) begin
               word_off <= 2'd0;
               rd_ptr   <= rd_ptr + PTR_ONE;
            end else begin
               word_off <= word_off + 2'd1;
            end
         end

         case ({do_fill, pop_line})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // Head presentation: combinational word select from registered line storage.
   assign Cache_pc    = fetch_pc;
   assign Cache_rd_en = rd_en_q;
   assign Empty       = empty;
   assign Inst        = empty ? 32'd0 : line_word(head_line_p0, word_off);
   assign Pc_out      = empty ? 32'd0 : ({head_lpc_p0, 4'b0000} + {28'd0, word_off, 2'b00});

endmodule

// File: tb/tb_i_fetch_queue.sv
// Scoreboard bench for i_fetch_queue with a 1-cycle i_cache model whose line at A holds
// {A/4, A/4+1, A/4+2, A/4+3}; expected PCs are queued by stimulus, checked by a monitor.
module tb_i_fetch_queue;

   logic         clk = 1'b0;
   logic         reset;
   logic [31:0]  Cache_pc;
   logic         Cache_rd_en;
   logic [127:0] Cache_dout = '0;
   logic         Cache_dout_valid = 1'b0;
   logic [31:0]  Inst;
   logic [31:0]  Pc_out;
   logic         Empty;
   logic         Dispatch_rd;
   logic [31:0]  Jmp_branch_address;
   logic         Jmp_branch_valid;

   int           n_tests = 0;
   int           n_fail  = 0;
   logic [31:0]  exp_q[$];
   logic [31:0]  req_log[$];

   always #5 clk = ~clk;

   i_fetch_queue #(
      .DEPTH    (4),
      .RESET_PC (32'h0)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .Cache_pc           (Cache_pc),
      .Cache_rd_en        (Cache_rd_en),
      .Cache_dout         (Cache_dout),
      .Cache_dout_valid   (Cache_dout_valid),
      .Inst               (Inst),
      .Pc_out             (Pc_out),
      .Empty              (Empty),
      .Dispatch_rd        (Dispatch_rd),
      .Jmp_branch_address (Jmp_branch_address),
      .Jmp_branch_valid   (Jmp_branch_valid)
   );

   function automatic logic [127:0] line_of(input logic [31:0] a);
      logic [31:0] w;
      w = a >> 2;
      return {w, w + 32'd1, w + 32'd2, w + 32'd3};
   endfunction

   // i_cache model: one-cycle read latency
   always @(posedge clk) begin
      Cache_dout_valid <= Cache_rd_en;
      Cache_dout       <= line_of(Cache_pc);
      if (Cache_rd_en) req_log.push_back(Cache_pc);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] log_at(input int i);
      return (req_log.size() > i) ? req_log[i] : 32'hDEAD_BEEF;
   endfunction

   task automatic push_seq(input logic [31:0] start, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
   endtask

   task automatic drain(input int budget, output int cyc);
      cyc = 0;
      while (exp_q.size() != 0 && cyc < budget) begin
         @(negedge clk);
         cyc++;
      end
      chk("drain_done", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic wait_rd_en(input int budget);
      int c;
      c = 0;
      while (!Cache_rd_en && c < budget) begin
         @(negedge clk);
         c++;
      end
      chk("rd_en_wait", {31'd0, Cache_rd_en}, 32'd1);
   endtask

   task automatic redirect(input logic [31:0] tgt);
      Jmp_branch_valid   = 1'b1;
      Jmp_branch_address = tgt;
      exp_q.delete();
   endtask

   // Monitor: checks every instruction dispatch actually consumes
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         #2;
         if (!reset && !Jmp_branch_valid && Dispatch_rd && !Empty) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_inst: got pc %h expected none", Pc_out);
            end else begin
               e = exp_q.pop_front();
               chk("pc_out", Pc_out, e);
               chk("inst", Inst, e >> 2);
            end
         end
      end
   end

   logic [31:0] pat = 32'b1111_0000_1110_1111_1111_0011_1011_1111;

   initial begin
      int cyc;
      reset              = 1'b1;
      Dispatch_rd        = 1'b0;
      Jmp_branch_valid   = 1'b0;
      Jmp_branch_address = 32'h0;

      // 1: reset state, then fill to DEPTH and stall
      repeat (3) @(negedge clk);
      chk("rst_rd_en", {31'd0, Cache_rd_en}, 32'd0);
      chk("rst_empty", {31'd0, Empty}, 32'd1);
      chk("rst_inst", Inst, 32'd0);
      chk("rst_pc_out", Pc_out, 32'd0);
      chk("rst_cache_pc", Cache_pc, 32'd0);
      reset = 1'b0;
      req_log.delete();
      repeat (20) @(negedge clk);
      chk("fill_req_count", 32'(req_log.size()), 32'd4);
      for (int i = 0; i < 4; i++) chk("fill_req_pc", log_at(i), 32'(16 * i));
      chk("full_empty", {31'd0, Empty}, 32'd0);
      chk("full_inst", Inst, 32'd0);
      chk("full_pc_out", Pc_out, 32'd0);
      chk("full_rd_en", {31'd0, Cache_rd_en}, 32'd0);

      // 2: continuous drain, one instruction per cycle
      push_seq(32'h0, 32);
      Dispatch_rd = 1'b1;
      drain(200, cyc);
      Dispatch_rd = 1'b0;
      chk("stream_cycles", 32'(cyc), 32'd32);
      chk("refetch_0x40", log_at(4), 32'h40);

      // 3: redirect to 0x88 with a request in flight
      redirect(32'h200);
      @(negedge clk);
      Jmp_branch_valid = 1'b0;
      wait_rd_en(10);
      req_log.delete();
      redirect(32'h88);
      push_seq(32'h88, 14);
      Dispatch_rd = 1'b1;
      @(negedge clk);
      Jmp_branch_valid = 1'b0;
      chk("redir_empty1", {31'd0, Empty}, 32'd1);
      @(negedge clk);
      chk("redir_empty2", {31'd0, Empty}, 32'd1);
      chk("redir_rd_en", {31'd0, Cache_rd_en}, 32'd1);
      chk("redir_cache_pc", Cache_pc, 32'h80);
      @(negedge clk);
      chk("redir_empty3", {31'd0, Empty}, 32'd1);
      @(negedge clk);
      chk("redir_first_valid", {31'd0, Empty}, 32'd0);
      chk("redir_first_pc", Pc_out, 32'h88);
      chk("redir_first_inst", Inst, 32'h22);
      drain(100, cyc);
      Dispatch_rd = 1'b0;
      chk("stale_req", log_at(0), 32'h200);
      chk("redir_req", log_at(1), 32'h80);

      // 4: redirect coinciding with a returning line
      redirect(32'h300);
      @(negedge clk);
      Jmp_branch_valid = 1'b0;
      wait_rd_en(10);
      @(negedge clk);
      chk("resp_present", {31'd0, Cache_dout_valid}, 32'd1);
      redirect(32'h44);
      push_seq(32'h44, 3);
      @(negedge clk);
      Jmp_branch_valid = 1'b0;
      chk("coinc_empty", {31'd0, Empty}, 32'd1);
      repeat (3) @(negedge clk);
      chk("coinc_pc", Pc_out, 32'h44);
      chk("coinc_inst", Inst, 32'h11);
      Dispatch_rd = 1'b1;
      drain(50, cyc);
      Dispatch_rd = 1'b0;

      // 5: irregular drain across fetch_pc wrap, fills racing last-word drains
      redirect(32'hFFFF_FFF8);
      push_seq(32'hFFFF_FFF8, 200);
      @(negedge clk);
      Jmp_branch_valid = 1'b0;
      for (int c = 0; c < 100; c++) begin
         Dispatch_rd = pat[c % 32];
         @(negedge clk);
      end
      Dispatch_rd = 1'b0;
      chk("wrap_progress", {31'd0, (exp_q.size() < 150)}, 32'd1);

      // 6: reset mid-stream with a response in flight
      redirect(32'h400);
      push_seq(32'h400, 100);
      Dispatch_rd = 1'b1;
      @(negedge clk);
      Jmp_branch_valid = 1'b0;
      repeat (8) @(negedge clk);
      wait_rd_en(10);
      reset       = 1'b1;
      Dispatch_rd = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk("mid_rst_rd_en", {31'd0, Cache_rd_en}, 32'd0);
      chk("mid_rst_empty", {31'd0, Empty}, 32'd1);
      chk("mid_rst_inst", Inst, 32'd0);
      chk("mid_rst_pc_out", Pc_out, 32'd0);
      chk("mid_rst_cache_pc", Cache_pc, 32'd0);
      chk("mid_rst_stale_resp", {31'd0, Cache_dout_valid}, 32'd1);
      reset = 1'b0;
      req_log.delete();
      @(negedge clk);
      chk("post_rst_empty", {31'd0, Empty}, 32'd1);
      chk("post_rst_rd_en", {31'd0, Cache_rd_en}, 32'd1);
      chk("post_rst_cache_pc", Cache_pc, 32'd0);
      push_seq(32'h0, 8);
      Dispatch_rd = 1'b1;
      drain(50, cyc);
      Dispatch_rd = 1'b0;
      chk("post_rst_req", log_at(0), 32'h0);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
